// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad lock supervisor.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        UNLOCKED = 3'd2,
        PROGRAM  = 3'd3,
        LOCKOUT  = 3'd4
    } lock_state_t;

    localparam int unsigned DIGIT_MAX = 9;

    // Constant-evaluable 10^n, used to size and wrap the decimal entry buffer.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    // Output flags for a state, ordered {unlocked, locked_out, prog_mode}.
    function automatic logic [2:0] state_flags(input lock_state_t s);
        case (s)
            UNLOCKED: return 3'b100;
            PROGRAM:  return 3'b101;
            LOCKOUT:  return 3'b010;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal shift buffer holding the last DIGITS keyed digits, plus a
// saturating count of how many digits have been entered.
module digit_accum
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned VAL_W  = 14,
    parameter int unsigned LEN_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [VAL_W-1:0] value,
    output logic [LEN_W-1:0] len
);

    // Dropping the top digit before shifting keeps value below 10^DIGITS.
    localparam int unsigned MODULUS = pow10(DIGITS - 1);

    // Shift in a new digit; clear wins over push.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
            len   <= '0;
        end else if (push) begin
            value <= VAL_W'((32'(value) % MODULUS) * 32'd10 + 32'(digit));
            if (len != LEN_W'(DIGITS)) begin
                len <= len + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/lock_supervisor.sv
// Keypad door lock sequencer: digit entry, code compare, unlock window,
// failed-attempt lockout and guarded code reprogramming.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no digits held; enter here counts as a failed attempt
// ENTRY    | collecting digits; timeout discards the partial entry
// UNLOCKED | door open for UNLOCK_CYCLES; prog_req enters PROGRAM
// PROGRAM  | door still open; a full-length submit becomes the new code
// LOCKOUT  | all inputs ignored for LOCKOUT_CYCLES, then fails clear
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned CODE_DIGITS    = 4,
    parameter int unsigned RESET_CODE     = 1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 10,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned ENTRY_TIMEOUT  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         key,
    input  logic                               pressed,
    input  logic                               enter,
    input  logic                               prog_req,
    output logic                               unlocked,
    output logic                               locked_out,
    output logic                               prog_mode,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [$clog2(CODE_DIGITS+1)-1:0]   entry_len
);

    localparam int unsigned VAL_W   = $clog2(pow10(CODE_DIGITS));
    localparam int unsigned FC_W    = $clog2(MAX_FAILS + 1);
    localparam int unsigned LEN_W   = $clog2(CODE_DIGITS + 1);
    localparam int unsigned TMR_A   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_MAX = (TMR_A > ENTRY_TIMEOUT) ? TMR_A : ENTRY_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    // Timers load N-1 so the terminal count (0) is the Nth cycle in state.
    localparam logic [TMR_W-1:0] T_UNLOCK  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_ENTRY   = TMR_W'(ENTRY_TIMEOUT - 1);

    lock_state_t      state;
    logic [2:0]       flags;
    logic [TMR_W-1:0] timer;
    logic [VAL_W-1:0] code;
    logic [VAL_W-1:0] acc_value;
    logic [LEN_W-1:0] acc_len;

    logic             in_keyed;
    logic             digit_ok;
    logic             push;
    logic             submit;
    logic             tmr_done;
    logic             timeout;
    logic             entry_full;
    logic             code_match;
    logic [FC_W-1:0]  fail_next;
    logic             fail_limit;

    assign in_keyed   = (state == IDLE) || (state == ENTRY) || (state == PROGRAM);
    assign digit_ok   = pressed && (key <= 4'(DIGIT_MAX));
    assign push       = in_keyed && digit_ok && !enter;
    assign submit     = in_keyed && enter;
    assign tmr_done   = (timer == '0);
    assign timeout    = ((state == ENTRY) || (state == PROGRAM)) && tmr_done && !enter && !push;
    assign entry_full = (acc_len == LEN_W'(CODE_DIGITS));
    assign code_match = entry_full && (acc_value == code);
    assign fail_next  = fail_count + FC_W'(1);
    assign fail_limit = (fail_next == FC_W'(MAX_FAILS));

    assign {unlocked, locked_out, prog_mode} = flags;
    assign entry_len = acc_len;

    digit_accum #(
        .DIGITS (CODE_DIGITS),
        .VAL_W  (VAL_W),
        .LEN_W  (LEN_W)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (submit || timeout),
        .push  (push),
        .digit (key),
        .value (acc_value),
        .len   (acc_len)
    );

    // Sequencer: state, shared down-counter, stored code, failure count and
    // registered output flags all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flags      <= '0;
            timer      <= '0;
            code       <= VAL_W'(RESET_CODE);
            fail_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enter) begin
                        fail_count <= fail_next;
                        if (fail_limit) begin
                            state <= LOCKOUT;
                            flags <= state_flags(LOCKOUT);
                            timer <= T_LOCKOUT;
                        end
                    end else if (push) begin
                        state <= ENTRY;
                        flags <= state_flags(ENTRY);
                        timer <= T_ENTRY;
                    end
                end

                ENTRY: begin
                    if (enter) begin
                        if (code_match) begin
                            state      <= UNLOCKED;
                            flags      <= state_flags(UNLOCKED);
                            timer      <= T_UNLOCK;
                            fail_count <= '0;
                        end else begin
                            fail_count <= fail_next;
                            if (fail_limit) begin
                                state <= LOCKOUT;
                                flags <= state_flags(LOCKOUT);
                                timer <= T_LOCKOUT;
                            end else begin
                                state <= IDLE;
                                flags <= state_flags(IDLE);
                            end
                        end
                    end else if (push) begin
                        timer <= T_ENTRY;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        flags <= state_flags(IDLE);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                UNLOCKED: begin
                    // prog_req is honoured even on the expiry cycle.
                    if (prog_req) begin
                        state <= PROGRAM;
                        flags <= state_flags(PROGRAM);
                        timer <= T_ENTRY;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        flags <= state_flags(IDLE);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                PROGRAM: begin
                    if (enter) begin
                        if (entry_full) begin
                            code <= acc_value;
                        end
                        state <= IDLE;
                        flags <= state_flags(IDLE);
                    end else if (push) begin
                        timer <= T_ENTRY;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        flags <= state_flags(IDLE);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                LOCKOUT: begin
                    if (tmr_done) begin
                        state      <= IDLE;
                        flags      <= state_flags(IDLE);
                        fail_count <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    flags <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Bench for lock_supervisor: vector tables plus multi-cycle hold sequences,
// with expected outputs queued as each cycle is driven.
module tb_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       pressed;
    logic       enter;
    logic       prog_req;
    logic       unlocked;
    logic       locked_out;
    logic       prog_mode;
    logic [1:0] fail_count;
    logic [2:0] entry_len;

    lock_supervisor dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .pressed    (pressed),
        .enter      (enter),
        .prog_req   (prog_req),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .prog_mode  (prog_mode),
        .fail_count (fail_count),
        .entry_len  (entry_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] key;
        logic       pressed;
        logic       enter;
        logic       prog_req;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [7:0] pack(input logic ul, input logic lo, input logic pm,
                                        input int fc, input int len);
        logic [1:0] f;
        logic [2:0] l;
        f = 2'(fc);
        l = 3'(len);
        return {ul, lo, pm, f, l};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input int k, input logic p,
                                input logic en, input logic pr, input logic ul, input logic lo,
                                input logic pm, input int fc, input int len);
        vec_t v;
        v.name = nm; v.rst = r; v.key = 4'(k); v.pressed = p; v.enter = en; v.prog_req = pr;
        v.exp = pack(ul, lo, pm, fc, len);
        return v;
    endfunction

    task automatic add(input string nm, input logic r, input int k, input logic p, input logic en,
                       input logic pr, input logic ul, input logic lo, input logic pm,
                       input int fc, input int len);
        tbl.push_back(mk(nm, r, k, p, en, pr, ul, lo, pm, fc, len));
    endtask

    // Four digits with entry_len expected to climb 1..4.
    task automatic add_code(input string nm, input int d0, input int d1, input int d2, input int d3,
                            input logic ul, input logic pm, input int fc);
        add(nm, 0, d0, 1, 0, 0, ul, 0, pm, fc, 1);
        add(nm, 0, d1, 1, 0, 0, ul, 0, pm, fc, 2);
        add(nm, 0, d2, 1, 0, 0, ul, 0, pm, fc, 3);
        add(nm, 0, d3, 1, 0, 0, ul, 0, pm, fc, 4);
    endtask

    task automatic compare();
        logic [7:0] act;
        logic [7:0] e;
        string      nm;
        act = {unlocked, locked_out, prog_mode, fail_count, entry_len};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: output %b with no expectation queued", act);
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got ul=%b lo=%b pm=%b fc=%0d len=%0d, want ul=%b lo=%b pm=%b fc=%0d len=%0d",
                     nm, $time, act[7], act[6], act[5], act[4:3], act[2:0],
                     e[7], e[6], e[5], e[4:3], e[2:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; key = v.key; pressed = v.pressed; enter = v.enter; prog_req = v.prog_req;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic hold(input string nm, input int n, input int k, input logic p, input logic en,
                        input logic ul, input logic lo, input logic pm, input int fc, input int len);
        vec_t v;
        v = mk(nm, 0, k, p, en, 0, ul, lo, pm, fc, len);
        for (int i = 0; i < n; i++) begin
            drive(v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; key = 4'd0; pressed = 1'b0; enter = 1'b0; prog_req = 1'b0;
        #2;

        // Reset, then the default code unlocks.
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code("enter_1234", 1, 2, 3, 4, 0, 0, 0);
        add("submit_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        run_table();
        hold("unlock_keys_ignored", 4, 5, 1, 0, 1, 0, 0, 0, 0);
        hold("unlock_enter_ignored", 5, 0, 0, 1, 1, 0, 0, 0, 0);
        hold("unlock_end", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three wrong codes escalate to lockout.
        add_code("wrong1", 1, 2, 3, 5, 0, 0, 0);
        add("fail1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add_code("wrong2", 1, 2, 3, 5, 0, 0, 1);
        add("fail2", 0, 0, 0, 1, 0, 0, 0, 0, 2, 0);
        add_code("wrong3", 1, 2, 3, 5, 0, 0, 2);
        add("lockout_start", 0, 0, 0, 1, 0, 0, 1, 0, 3, 0);
        run_table();
        hold("lockout_keys", 30, 1, 1, 0, 0, 1, 0, 3, 0);
        hold("lockout_enter", 33, 0, 0, 1, 0, 1, 0, 3, 0);
        hold("lockout_end", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code("after_lock", 1, 2, 3, 4, 0, 0, 0);
        add("after_lock_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        // Reprogram to 9876, old code rejected, new code accepted, reset restores.
        add("prog_enter", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        add_code("prog_digits", 9, 8, 7, 6, 1, 1, 0);
        add("prog_store", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_code("old_code", 1, 2, 3, 4, 0, 0, 0);
        add("old_code_fail", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add_code("new_code", 9, 8, 7, 6, 0, 0, 1);
        add("new_code_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add("rst_mid_unlock", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code("reset_code", 1, 2, 3, 4, 0, 0, 0);
        add("reset_code_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        run_table();

        // prog_req on the expiry cycle still enters PROGRAM; then it times out.
        hold("unlock_wait", 9, 0, 0, 0, 1, 0, 0, 0, 0);
        hold("prog_at_expiry", 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drive(mk("prog_at_expiry", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        hold("prog_wait", 31, 0, 0, 0, 1, 0, 1, 0, 0);
        hold("prog_timeout", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Short program submit leaves the code alone.
        add_code("code_kept", 1, 2, 3, 4, 0, 0, 0);
        add("code_kept_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add("prog_again", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        add("prog_short", 0, 5, 1, 0, 0, 1, 0, 1, 0, 1);
        add("prog_short", 0, 5, 1, 0, 0, 1, 0, 1, 0, 2);
        add("prog_short_sub", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_code("code_still", 1, 2, 3, 4, 0, 0, 0);
        add("code_still_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        run_table();
        hold("unlock_wait2", 9, 0, 0, 0, 1, 0, 0, 0, 0);
        hold("unlock_end2", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Entry timeout; invalid keys must not reload it.
        add("partial", 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add("partial", 0, 2, 1, 0, 0, 0, 0, 0, 0, 2);
        run_table();
        hold("bad_key10", 16, 10, 1, 0, 0, 0, 0, 0, 2);
        hold("bad_key15", 15, 15, 1, 0, 0, 0, 0, 0, 2);
        hold("entry_timeout", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("short", 0, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        add("short", 0, 4, 1, 0, 0, 0, 0, 0, 0, 2);
        add("short_fail", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

        // Invalid key and digit-with-enter dropped; 5-digit entry shifts to 1234.
        add("shift5", 0, 5, 1, 0, 0, 0, 0, 0, 1, 1);
        add("key12", 0, 12, 1, 0, 0, 0, 0, 0, 1, 1);
        add("shift1", 0, 1, 1, 0, 0, 0, 0, 0, 1, 2);
        add("shift2", 0, 2, 1, 0, 0, 0, 0, 0, 1, 3);
        add("shift3", 0, 3, 1, 0, 0, 0, 0, 0, 1, 4);
        add("shift4_sat", 0, 4, 1, 0, 0, 0, 0, 0, 1, 4);
        add("enter_wins", 0, 7, 1, 1, 0, 1, 0, 0, 0, 0);
        run_table();
        hold("unlock_wait3", 9, 0, 0, 0, 1, 0, 0, 0, 0);
        hold("unlock_end3", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Empty submits lock out; reset at lockout cycle 20 aborts it.
        add("empty1", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add("empty2", 0, 0, 0, 1, 0, 0, 0, 0, 2, 0);
        add("empty3_lock", 0, 0, 0, 1, 0, 0, 1, 0, 3, 0);
        run_table();
        hold("lock_mid", 19, 0, 0, 0, 0, 1, 0, 3, 0);
        add("rst_mid_lock", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code("post_rst_code", 1, 2, 3, 4, 0, 0, 0);
        add("post_rst_ok", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
